// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N = 4;

endpackage

// File: rtl/decode24_case.sv
// 2-to-4 enable decoder: one-hot y selected by x while en is high, all low otherwise.
module decode24_case (
  input  logic [1:0] x,
  input  logic       en,
  output logic [3:0] y
);

  // Case-based decode gated by the enable.
  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (x)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with hold timeout and a mandatory dead cycle
// between owners. Outputs come only from registers (gnt is a decode of them).
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no grant; arbitrate when en && |req
// GRANT | gnt_idx owns the resource; hold_cnt counts
module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  // A zero MAX_HOLD disables the limit but still needs a 1-bit counter.
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  arb_state_t    state, state_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [1:0]    idx_nxt;
  logic [HW-1:0] hold_cnt, cnt_nxt;
  logic          to_nxt;
  logic [2:0]    pick;
  logic          hold_expire;

  // Returns {found, index} of the first request at or after p, wrapping mod 4.
  // The loop runs from the farthest offset down so the nearest one wins.
  function automatic logic [2:0] rr_pick(input logic [ARB_N-1:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick        = rr_pick(req, ptr);
  assign hold_expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign gnt_vld     = (state == GRANT);

  // Next-state logic: voluntary release and enable drop outrank the timeout.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
    cnt_nxt   = hold_cnt;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en && pick[2]) begin
          state_nxt = GRANT;
          idx_nxt   = pick[1:0];
        end
      end
      GRANT: begin
        if (!req[gnt_idx] || !en) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + 2'd1;
          cnt_nxt   = '0;
        end else if (hold_expire) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + 2'd1;
          cnt_nxt   = '0;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, pointer, owner, hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      gnt_idx  <= 2'd0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      hold_cnt <= cnt_nxt;
      timeout  <= to_nxt;
    end
  end

  decode24_case u_dec (
    .x  (gnt_idx),
    .en (gnt_vld),
    .y  (gnt)
  );

endmodule
